pam_unsigned_mult_pipe: RTL

PAM_UNSIGNED_MULT_PIPE -- requirements
Module: pam_unsigned_mult_pipe

---
 rtl/pam_mult_pkg.sv | 12 +
 rtl/pam_pp_truncate.sv | 38 +++
 rtl/pam_unsigned_mult_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/pam_mult_pkg.sv
// Shared constants for the partial-product-truncating unsigned multiplier.
// Holds the default geometry and the per-transaction mode encoding.
package pam_mult_pkg;

  localparam int DEF_W    = 8;
  localparam int DEF_L    = 6;
  localparam int DEF_CMIN = DEF_W - 1;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

endpackage

// File: rtl/pam_pp_truncate.sv
// Combinational partial-product split: exact top rows, exact low rows, and
// the low rows with every bit below column CMIN dropped.
module pam_pp_truncate
  import pam_mult_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int L    = DEF_L,
  parameter int CMIN = W - 1
) (
  input  logic [W-1:0]   x_i,
  input  logic [W-1:0]   y_i,
  output logic [2*W-1:0] hi_rows_o,
  output logic [2*W-1:0] lo_exact_o,
  output logic [2*W-1:0] lo_kept_o
);

  // Mask of multiplier bits that belong to the approximated rows.
  localparam logic [W-1:0]   LO_MASK = W'((32'd1 << L) - 32'd1);
  localparam logic [2*W-1:0] ONE     = {{(2*W-1){1'b0}}, 1'b1};

  logic [2*W-1:0] y_w;

  assign y_w        = {{W{1'b0}}, y_i};
  assign hi_rows_o  = {{W{1'b0}}, x_i & ~LO_MASK} * y_w;
  assign lo_exact_o = {{W{1'b0}}, x_i & LO_MASK} * y_w;

  always_comb begin
    lo_kept_o = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if ((i < L) && ((i + j) >= CMIN) && x_i[i] && y_i[j]) begin
          lo_kept_o = lo_kept_o + (ONE << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/pam_unsigned_mult_pipe.sv
// Two-stage valid/ready pipeline around pam_pp_truncate: S1 holds the row
// sums, S2 holds the final product. Whole pipe advances on one enable.
module pam_unsigned_mult_pipe
  import pam_mult_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int L    = DEF_L,
  parameter int CMIN = W - 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic           in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_z,
  output logic           out_mode
);

  // Handshake: a beat moves on valid & ready. The pipe advances when the
  // output slot is empty or being retired; in_ready mirrors that enable.
  logic en;

  logic [2*W-1:0] hi_rows, lo_exact, lo_kept;

  logic           s1_valid_q, s1_valid_d;
  logic [2*W-1:0] s1_hi_q, s1_lo_q;
  logic           s1_mode_q;

  logic           out_valid_q, out_valid_d;
  logic [2*W-1:0] out_z_q, out_z_d;
  logic           out_mode_q, out_mode_d;

  pam_pp_truncate #(
    .W    (W),
    .L    (L),
    .CMIN (CMIN)
  ) u_pp (
    .x_i        (in_x),
    .y_i        (in_y),
    .hi_rows_o  (hi_rows),
    .lo_exact_o (lo_exact),
    .lo_kept_o  (lo_kept)
  );

  assign en = ~out_valid_q | out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_mode_d  = out_mode_q;
    if (en) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_z_d    = s1_hi_q + s1_lo_q;
        out_mode_d = s1_mode_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_mode_q  <= MODE_APPROX;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_mode_q  <= out_mode_d;
    end
  end

  // S1 payload is only ever read behind s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      s1_hi_q   <= hi_rows;
      s1_lo_q   <= (in_mode == MODE_EXACT) ? lo_exact : lo_kept;
      s1_mode_q <= in_mode;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_mode  = out_mode_q;

endmodule
